aes_inv_cipher: RTL
===================

# aes_inv_cipher

Iterative AES-128 inverse cipher (FIPS-197 decryption) that recovers the plain text from a cipher text and key. It is the decrypt-side counterpart of the AES-128 encryption core and shares that core's `shared_pkg` widths and valid-strobe conventions. It supports loopback checking: encryption core output fed into this block must return the original plain text. It expands the full key schedule once per request, then runs one inverse round per clock.

## Interface

- `KEY_L`, 128 (from `shared_pkg`): cipher key width; only 128 is supported.
- `DATA_W`, 128 (from `shared_pkg`): block width; only 128 is supported.

- `clk`  input  1  system clock; all state changes on the rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `valid_in`  input  1  request strobe; sampled only when `busy`=0.
- `cipher_key`  input  KEY_L  key; captured on the accepting edge.
- `cipher_text`  input  DATA_W  block to decrypt; captured on the accepting edge.
- `plain_text`  output  DATA_W  decrypted block; registered and held until the next completion.
- `valid_out`  output  1  one-cycle pulse when `plain_text` is updated.
- `busy`  output  1  high while a request is in progress.

## Operation

- Byte order follows FIPS-197: bit [127:120] is byte 0, and the state is column-major.
- FSM states:
  - IDLE: `valid_in`=1 → capture key into rk[0] and `cipher_text` into the state register, set `busy`, counter←1, go to KEXP. `valid_in`=0 → stay in IDLE.
  - KEXP: rk[i] ← KeyExpand(rk[i-1], Rcon[i]). Rcon = 01,02,04,08,10,20,40,80,1b,36. Uses 4 forward S-boxes for SubWord(RotWord). At i=10 go to ADD.
  - ADD: state ← state ^ rk[10]; counter←9; go to DEC.
  - DEC, round r:
    - r≥1: state ← InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk[r]).
    - r=0: `plain_text` ← InvSubBytes(InvShiftRows(state)) ^ rk[0], `valid_out`←1, `busy`←0, go to IDLE.
- Round keys are held in an 11×128 register file. Inverse S-box: 16 instances, combinational.
- `valid_in` while `busy`=1 is ignored, with no queueing and no error flag. Upstream must wait for `busy`=0.
- `cipher_key` and `cipher_text` may change freely after the accepting edge.
- Reset, at any time including mid-operation:
  - Immediately: `plain_text`=0, `valid_out`=0, `busy`=0, FSM=IDLE, counter=0.
  - The in-flight request is dropped and produces no `valid_out`.
  - Round-key file contents are don't-care.

## Timing

- Accepting edge E0: `valid_in`=1 while `busy`=0 (state IDLE).
- E1–E10: KEXP.
- E11: ADD.
- E12–E21: DEC rounds 9…0.
- At E21, `plain_text` updates and `valid_out` rises. `valid_out` is high for exactly one cycle, E21–E22.
- `busy` is high from E0 to E21. It is low in the `valid_out` cycle, so a new request can be accepted at E22.
- Latency: 21 cycles from the accepting edge to `valid_out`. Throughput: one block per 22 cycles.
- `valid_out` is never asserted in consecutive cycles.
- `plain_text` is stable between pulses.

## Test plan

- Reset state: assert `reset_n`=0 asynchronously (between edges) → `plain_text`=0, `valid_out`=0, `busy`=0 immediately, with no clock edge needed.
- FIPS-197 C.1 vector:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Response: `plain_text`=00112233445566778899aabbccddeeff, with `valid_out` exactly 21 cycles after acceptance.
- FIPS-197 B vector and request-while-busy:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32. Then toggle `valid_in` with garbage inputs while `busy`=1.
  - Response: pt=3243f6a8885a308d313198a2e0370734, and exactly one `valid_out`.
- All-zero key:
  - Stimulus: key 0, ct 66e94bd4ef8a2c3b884cfa59ca342b2e.
  - Response: pt=0. A second request accepted at E22 completes at E43 with a correct result.
- Mid-operation reset: pulse `reset_n` low at cycle 15 of a C.1 request → no `valid_out`; a following B-vector request decrypts correctly.
- Loopback: 1000 random key/plain pairs through the encryption core into this block, compared against the Python golden model → `plain_text` matches the original plain text every time.

Source files
------------

// File: rtl/shared_pkg.sv
// Widths shared by the AES-128 encryption and decryption cores.
package shared_pkg;
    localparam int KEY_L  = 128;
    localparam int DATA_W = 128;
endpackage

// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 inverse cipher: expands the full key schedule once per request,
// then runs one inverse round per clock, pulsing valid_out when plain_text is updated.
module aes_inv_cipher
    import shared_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              valid_in,
    input  logic [KEY_L-1:0]  cipher_key,
    input  logic [DATA_W-1:0] cipher_text,
    output logic [DATA_W-1:0] plain_text,
    output logic              valid_out,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, KEXP, ADD, DEC} fsm_t;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [0:255] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // GF(2^8) multiply by a 4-bit constant (9, b, d, e for InvMixColumns).
    function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] k);
        logic [7:0] b2, b4, b8;
        b2 = xtime(b);
        b4 = xtime(b2);
        b8 = xtime(b4);
        return ({8{k[0]}} & b) ^ ({8{k[1]}} & b2) ^ ({8{k[2]}} & b4) ^ ({8{k[3]}} & b8);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t;
        logic [127:0] n;
        t = {SBOX[k[23:16]], SBOX[k[15:8]], SBOX[k[7:0]], SBOX[k[31:24]]} ^ {rc, 24'h0};
        n[127:96] = k[127:96] ^ t;
        n[95:64]  = k[95:64]  ^ n[127:96];
        n[63:32]  = k[63:32]  ^ n[95:64];
        n[31:0]   = k[31:0]   ^ n[63:32];
        return n;
    endfunction

    // Byte (row r, column c) lives at index 4*c + r, counted from the MSB.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int b = 0; b < 16; b++)
            o[127-8*b -: 8] = INV_SBOX[s[127-8*b -: 8]];
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9);
            o[119-32*c -: 8] = gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd);
            o[111-32*c -: 8] = gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb);
            o[103-32*c -: 8] = gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he);
        end
        return o;
    endfunction

    fsm_t              fsm_q, fsm_d;
    logic [3:0]        cnt_q;
    logic [DATA_W-1:0] state_q;
    logic [KEY_L-1:0]  rk [0:10];
    logic [DATA_W-1:0] round_out;

    assign busy      = (fsm_q != IDLE);
    assign round_out = inv_sub_bytes(inv_shift_rows(state_q)) ^ rk[cnt_q];

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE:    if (valid_in) fsm_d = KEXP;
            KEXP:    if (cnt_q == 4'd10) fsm_d = ADD;
            ADD:     fsm_d = DEC;
            DEC:     if (cnt_q == 4'd0) fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) fsm_q <= IDLE;
        else          fsm_q <= fsm_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            state_q    <= '0;
            plain_text <= '0;
            valid_out  <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            case (fsm_q)
                IDLE: if (valid_in) begin
                    state_q <= cipher_text;
                    cnt_q   <= 4'd1;
                end
                KEXP: cnt_q <= cnt_q + 4'd1;
                ADD: begin
                    state_q <= state_q ^ rk[10];
                    cnt_q   <= 4'd9;
                end
                DEC: if (cnt_q == 4'd0) begin
                    plain_text <= round_out;
                    valid_out  <= 1'b1;
                end else begin
                    state_q <= inv_mix_columns(round_out);
                    cnt_q   <= cnt_q - 4'd1;
                end
                default: ;
            endcase
        end
    end

    // NOTE: the round-key file is deliberately left without reset; it is always rewritten
    // before being read, so a reset would only add routing to a large memory.
    always_ff @(posedge clk) begin
        if (fsm_q == IDLE && valid_in) rk[0] <= cipher_key;
        else if (fsm_q == KEXP)        rk[cnt_q] <= key_expand(rk[cnt_q - 4'd1], rcon(cnt_q));
    end

endmodule
